// File: rtl/accel_stall_ctrl.sv
// Issue/stall controller for the multi-cycle accelerators (NTT, PWAM, MUL, Keccak).
// Sends a start pulse to the selected unit and stalls the pipeline until done, flush or timeout.
module accel_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             issue_valid,
    input  logic [1:0]       issue_unit,
    input  logic             flush,
    input  logic [3:0]       unit_done,
    input  logic             err_clr,
    output logic [3:0]       unit_start,
    output logic             ntt_stall,
    output logic             pwam_stall,
    output logic             mulstall,
    output logic             keccak_stall,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] last_latency
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [1:0]       cur_unit_reg, cur_unit_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [CNT_W-1:0] last_latency_reg, last_latency_next;
    logic             timeout_err_reg, timeout_err_next;

    logic       accept;
    logic       done_hit;
    logic       timeout_hit;
    logic       hold;
    logic [3:0] stall_vec;

    assign accept      = (state_reg == S_IDLE) && issue_valid && !flush;
    assign done_hit    = (state_reg == S_WAIT) && unit_done[cur_unit_reg];
    assign timeout_hit = (state_reg == S_WAIT) && !done_hit && (counter_reg == CNT_LAST);
    // An in-flight op keeps its stall line until the cycle it is released.
    assign hold        = (state_reg != S_IDLE) && !flush && !done_hit && !timeout_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg        <= S_IDLE;
            cur_unit_reg     <= 2'd0;
            counter_reg      <= '0;
            last_latency_reg <= '0;
            timeout_err_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cur_unit_reg     <= cur_unit_next;
            counter_reg      <= counter_next;
            last_latency_reg <= last_latency_next;
            timeout_err_reg  <= timeout_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cur_unit_next     = cur_unit_reg;
        counter_next      = counter_reg;
        last_latency_next = last_latency_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next    = S_ISSUE;
                    cur_unit_next = issue_unit;
                end
            end
            S_ISSUE: begin
                state_next   = flush ? S_IDLE : S_WAIT;
                counter_next = '0;
            end
            S_WAIT: begin
                // Flush takes priority: an aborted op records neither latency nor timeout.
                if (flush) begin
                    state_next = S_IDLE;
                end else if (done_hit) begin
                    state_next        = S_IDLE;
                    last_latency_next = counter_reg + 1'b1;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                end else if (counter_reg != CNT_LAST) begin
                    counter_next = counter_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        timeout_err_next = timeout_err_reg;
        if (timeout_hit && !flush) begin
            timeout_err_next = 1'b1;
        end else if (err_clr) begin
            timeout_err_next = 1'b0;
        end
    end

    always_comb begin
        unit_start = 4'b0000;
        if ((state_reg == S_ISSUE) && !flush) begin
            unit_start[cur_unit_reg] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_stall
        assign stall_vec[gi] = (accept && (issue_unit == 2'(gi)))
                             || (hold && (cur_unit_reg == 2'(gi)));
    end

    assign ntt_stall    = stall_vec[0];
    assign pwam_stall   = stall_vec[1];
    assign mulstall     = stall_vec[2];
    assign keccak_stall = stall_vec[3];
    assign busy         = (state_reg != S_IDLE);
    assign timeout_err  = timeout_err_reg;
    assign last_latency = last_latency_reg;

endmodule

// File: tb/tb_accel_stall_ctrl.sv
// Self-checking bench for accel_stall_ctrl: directed scenarios then random traffic,
// all compared cycle by cycle against an operation-level reference model.
module tb_accel_stall_ctrl;

    localparam int TMO = 1024;
    localparam int CW  = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          issue_valid = 1'b0;
    logic [1:0]    issue_unit = 2'd0;
    logic          flush = 1'b0;
    logic [3:0]    unit_done = 4'd0;
    logic          err_clr = 1'b0;
    logic [3:0]    unit_start;
    logic          ntt_stall, pwam_stall, mulstall, keccak_stall;
    logic          busy, timeout_err;
    logic [CW-1:0] last_latency;

    accel_stall_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_unit(issue_unit),
        .flush(flush), .unit_done(unit_done), .err_clr(err_clr), .unit_start(unit_start),
        .ntt_stall(ntt_stall), .pwam_stall(pwam_stall), .mulstall(mulstall),
        .keccak_stall(keccak_stall), .busy(busy), .timeout_err(timeout_err),
        .last_latency(last_latency)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 0;

    // Reference model: an op in flight is described by its unit and its age in
    // cycles since acceptance (age 1 = start cycle, age k>=2 = (k-1)th wait cycle).
    bit m_active = 0;
    int m_unit   = 0;
    int m_age    = 0;
    int m_lat    = 0;
    bit m_terr   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic eval_and_update();
        bit done_hit, to_hit;
        int stall_u;
        logic [3:0] exp_start, exp_stall;
        done_hit = m_active && (m_age >= 2) && unit_done[m_unit];
        to_hit   = m_active && (m_age >= 2) && !done_hit && (m_age - 2 == TMO - 1);
        exp_start = 4'd0;
        if (m_active && m_age == 1 && !flush) exp_start[m_unit] = 1'b1;
        stall_u = -1;
        if (!m_active) begin
            if (issue_valid && !flush) stall_u = int'(issue_unit);
        end else if (!flush && !done_hit && !to_hit) begin
            stall_u = m_unit;
        end
        exp_stall = 4'd0;
        if (stall_u >= 0) exp_stall[stall_u] = 1'b1;

        if (chk_en) begin
            chk("start", 32'(unit_start), 32'(exp_start));
            chk("stall", 32'({keccak_stall, mulstall, pwam_stall, ntt_stall}), 32'(exp_stall));
            chk("busy", 32'(busy), 32'(m_active));
            chk("terr", 32'(timeout_err), 32'(m_terr));
            chk("lat", 32'(last_latency), 32'(m_lat));
        end

        if (RST) begin
            m_active = 0; m_unit = 0; m_age = 0; m_lat = 0; m_terr = 0;
        end else begin
            if (!m_active) begin
                if (issue_valid && !flush) begin
                    m_active = 1; m_unit = int'(issue_unit); m_age = 1;
                end
            end else if (flush) begin
                $display("op unit=%0d flushed at age %0d", m_unit, m_age);
                m_active = 0;
            end else if (done_hit) begin
                m_lat = m_age - 1;
                $display("op unit=%0d done latency=%0d", m_unit, m_lat);
                m_active = 0;
            end else if (to_hit) begin
                $display("op unit=%0d timeout", m_unit);
                m_active = 0;
            end else begin
                m_age++;
            end
            if (to_hit && !flush) m_terr = 1;
            else if (err_clr) m_terr = 0;
        end
    endtask

    task automatic step(input logic iv, input logic [1:0] iu, input logic fl,
                        input logic [3:0] dn, input logic clr, input logic rs);
        @(posedge CLK);
        #1;
        issue_valid = iv; issue_unit = iu; flush = fl;
        unit_done = dn; err_clr = clr; RST = rs;
        @(negedge CLK);
        eval_and_update();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (m_active && k < budget) begin
            step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
            k++;
        end
        chk("idle_budget", 32'(m_active), 32'd0);
    endtask

    initial begin
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk_en = 1;
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        idle_cycles(2);

        // MUL, done on 3rd wait cycle
        step(1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        idle_cycles(3);
        step(1'b0, 2'd0, 1'b0, 4'b0100, 1'b0, 1'b0);
        idle_cycles(1);
        chk("t1_lat", 32'(last_latency), 32'd3);

        // Keccak, done on first wait cycle, then immediate reissue
        step(1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("t2_lat", 32'(last_latency), 32'd1);
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("t2_restart", 32'(unit_start), 32'h8);
        step(1'b0, 2'd0, 1'b0, 4'b1000, 1'b0, 1'b0);

        // NTT timeout with wrong-unit done pulses
        step(1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < TMO + 20 && m_active; i++)
            step(1'b0, 2'd0, 1'b0, (i % 7 == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
        chk("t3_idle", 32'(m_active), 32'd0);
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("t3_terr", 32'(timeout_err), 32'd1);
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < TMO + 20 && m_active; i++)
            step(1'b0, 2'd0, 1'b0, 4'd0, (m_age - 1 == TMO) ? 1'b1 : 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("t3_setwins", 32'(timeout_err), 32'd1);
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0);

        // Flush in ISSUE, then flush on wait cycle 5
        step(1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        idle_cycles(1);
        step(1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle_cycles(5);
        step(1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        idle_cycles(1);
        chk("t4_lat", 32'(last_latency), 32'd1);

        // Reset mid-wait, then a late done
        step(1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        idle_cycles(3);
        step(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 4'b0100, 1'b0, 1'b0);

        // Done while idle, issue with flush while idle
        step(1'b0, 2'd0, 1'b0, 4'hF, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b1, 4'd0, 1'b0, 1'b0);
        idle_cycles(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] dn;
            for (int b = 0; b < 4; b++) dn[b] = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15) == 0, dn,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end
        wait_idle(TMO + 20);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
